// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared constants and helpers for the AXI4 read controller
package axi_rd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Bytes per beat expressed as log2, which is what ARSIZE encodes.
    function automatic logic [2:0] calc_arsize(input int data_width);
        logic [2:0] size;
        size = '0;
        for (int i = 0; i < 7; i++) begin
            if ((1 << i) == (data_width / 8)) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/axi_read_ctrl.sv
// rtl/axi_read_ctrl.sv - single-outstanding AXI4 burst read master for the DDR read arbiter
module axi_read_ctrl
    import axi_rd_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0
) (
    input  logic                      sys_clk_i,
    input  logic                      reset_i,
    input  logic                      req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] rstart_addr_i,
    input  logic [7:0]                burst_size_i,
    output logic                      ack_o,
    output logic                      data_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] rdata_o,
    output logic                      done_o,
    output logic                      err_o,
    input  logic                      err_clr_i,
    output logic [AXI_ID_WIDTH-1:0]   arid_o,
    output logic [AXI_ADDR_WIDTH-1:0] araddr_o,
    output logic [7:0]                arlen_o,
    output logic [2:0]                arsize_o,
    output logic [1:0]                arburst_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    input  logic [AXI_ID_WIDTH-1:0]   rid_i,
    input  logic [AXI_DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    input  logic                      rvalid_i,
    output logic                      rready_o
);

    logic [1:0] state;
    logic [7:0] beat_cnt;
    logic       beat;
    logic       cnt_last;
    logic       beat_bad;

    assign arid_o    = AXI_ID_WIDTH'(AXI_ID);
    assign arsize_o  = calc_arsize(AXI_DATA_WIDTH);
    assign arburst_o = BURST_INCR;

    assign beat     = rvalid_i & rready_o;
    assign cnt_last = (beat_cnt == arlen_o);
    assign beat_bad = (rresp_i != RESP_OKAY) || (rid_i != AXI_ID_WIDTH'(AXI_ID));

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            ack_o        <= 1'b0;
            data_valid_o <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            arvalid_o    <= 1'b0;
            rready_o     <= 1'b0;
            araddr_o     <= '0;
            arlen_o      <= '0;
            rdata_o      <= '0;
        end else begin
            ack_o        <= 1'b0;
            data_valid_o <= 1'b0;
            done_o       <= 1'b0;
            // Clear first so any error set below in the same cycle wins.
            if (err_clr_i) begin
                err_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        araddr_o  <= rstart_addr_i;
                        arlen_o   <= burst_size_i;
                        beat_cnt  <= '0;
                        arvalid_o <= 1'b1;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        ack_o     <= 1'b1;
                        rready_o  <= 1'b1;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        rdata_o      <= rdata_i;
                        data_valid_o <= 1'b1;
                        beat_cnt     <= beat_cnt + 8'd1;
                        if (beat_bad) begin
                            err_o <= 1'b1;
                        end
                        // Whichever of rlast or the expected count arrives first ends the burst.
                        if (rlast_i || cnt_last) begin
                            rready_o <= 1'b0;
                            done_o   <= 1'b1;
                            state    <= ST_DONE;
                            if (rlast_i != cnt_last) begin
                                err_o <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
